// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin arbitration in IDLE, then one SETUP and one
// or more ACCESS cycles per transfer, with an optional PREADY wait timeout.
module apb_master_arb #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

    state_t            state_q;
    logic              psel_q, penable_q, pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              done0_q, done1_q, err0_q, err1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic [7:0]        wait_q;
    logic              owner_q;
    logic              last_q;

    logic              elig0, elig1, grant_any, grant_sel;
    logic [7:0]        wait_d;
    logic              timeout_hit, fin, fin_err;
    logic [DATA_W-1:0] fin_data;

    // A requester whose done pulse is showing this cycle sits out one arbitration.
    assign elig0     = req0 & ~done0_q;
    assign elig1     = req1 & ~done1_q;
    assign grant_any = elig0 | elig1;
    assign grant_sel = (elig0 & elig1) ? ~last_q : elig1;

    assign wait_d      = wait_q + 8'd1;
    assign timeout_hit = (TIMEOUT != 0) && (wait_d == TMO_LIM);
    // PREADY wins over a timeout landing on the same edge.
    assign fin         = PREADY | timeout_hit;
    assign fin_err     = ~PREADY;
    assign fin_data    = (PREADY && !pwrite_q) ? PRDATA : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            wait_q    <= 8'd0;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        state_q   <= SETUP;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        owner_q   <= grant_sel;
                        last_q    <= grant_sel;
                        pwrite_q  <= grant_sel ? wr1 : wr0;
                        paddr_q   <= grant_sel ? addr1 : addr0;
                        pwdata_q  <= grant_sel ? wdata1 : wdata0;
                        wait_q    <= 8'd0;
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    if (fin) begin
                        state_q   <= IDLE;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        if (owner_q) begin
                            done1_q  <= 1'b1;
                            err1_q   <= fin_err;
                            rdata1_q <= fin_data;
                        end else begin
                            done0_q  <= 1'b1;
                            err0_q   <= fin_err;
                            rdata0_q <= fin_data;
                        end
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb: single transfers, wait states, round-robin,
// timeout, PREADY-vs-timeout priority and asynchronous reset, plus a protocol monitor.
module tb_apb_master_arb;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    logic              PCLK, PRESETn;
    logic              req0, req1, wr0, wr1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              done0, done1, err0, err1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              PSEL, PENABLE, PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA, PRDATA;
    logic              PREADY, busy;
    logic [1:0]        dbg_state;

    int n_total = 0;
    int n_bad   = 0;

    apb_master_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .busy(busy), .dbg_state(dbg_state)
    );

    // clock / reset
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Drives PREADY high on ACCESS cycle number lat+1; returns ACCESS cycles seen.
    task automatic run_xfer(input int lat, input int max_cyc, output int pen);
        logic timed_out;
        pen = 0;
        timed_out = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            if (PENABLE) pen++;
            PREADY = PENABLE && (pen > lat);
            tick();
            if (done0 || done1) begin
                timed_out = 1'b0;
                break;
            end
        end
        PREADY = 1'b0;
        check("xfer_bound", timed_out, 1'b0);
    endtask

    // protocol monitor
    logic              prev_psel = 1'b0;
    logic              lat_wr;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    always @(negedge PCLK) begin
        if (PRESETn) begin
            check("psel_in_idle", PSEL & ~busy, 1'b0);
            check("pen_wo_psel", PENABLE & ~PSEL, 1'b0);
            check("pen_first_cycle", PENABLE & ~prev_psel, 1'b0);
            if (PSEL && !prev_psel) begin
                lat_wr = PWRITE;
                lat_addr = PADDR;
                lat_wdata = PWDATA;
            end else if (PSEL) begin
                check("paddr_stable", PADDR, lat_addr);
                check("pwrite_stable", PWRITE, lat_wr);
                check("pwdata_stable", PWDATA, lat_wdata);
            end
            prev_psel = PSEL;
        end else begin
            prev_psel = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pen;
        PRESETn = 1'b0;
        {req0, req1, wr0, wr1} = 4'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        PRDATA = '0; PREADY = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        check("rst_psel", PSEL, 1'b0);
        check("rst_penable", PENABLE, 1'b0);
        check("rst_pwrite", PWRITE, 1'b0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_done", {done0, done1, err0, err1}, 0);
        check("rst_rdata", {rdata0, rdata1}, 0);
        check("rst_busy", busy, 1'b0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        tick();

        // single write, zero-wait slave
        req0 = 1'b1; wr0 = 1'b1; addr0 = 4'h4; wdata0 = 32'hDEADBEEF; PREADY = 1'b1;
        check("w_idle_busy", busy, 1'b0);
        tick();
        check("w_setup_psel", PSEL, 1'b1);
        check("w_setup_pen", PENABLE, 1'b0);
        check("w_setup_paddr", PADDR, 4'h4);
        check("w_setup_pwrite", PWRITE, 1'b1);
        check("w_setup_pwdata", PWDATA, 32'hDEADBEEF);
        check("w_setup_busy", busy, 1'b1);
        tick();
        check("w_access_pen", PENABLE, 1'b1);
        check("w_access_done", done0, 1'b0);
        tick();
        check("w_done0", done0, 1'b1);
        check("w_err0", err0, 1'b0);
        check("w_rdata0", rdata0, 0);
        check("w_done1", done1, 1'b0);
        check("w_done_psel", PSEL, 1'b0);
        req0 = 1'b0; PREADY = 1'b0;
        tick();
        check("w_done_pulse", done0, 1'b0);

        // read with three wait cycles
        req1 = 1'b1; wr1 = 1'b0; addr1 = 4'h8; PRDATA = 32'h12345678;
        run_xfer(3, 20, pen);
        check("r_pen_cycles", pen, 4);
        check("r_done1", done1, 1'b1);
        check("r_err1", err1, 1'b0);
        check("r_rdata1", rdata1, 32'h12345678);
        check("r_done0", done0, 1'b0);
        req1 = 1'b0;
        tick();

        // both requesting: grants alternate 0,1,0,1
        PRDATA = 32'hCAFE0000;
        req0 = 1'b1; wr0 = 1'b0; addr0 = 4'h1;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 4'h2;
        for (int t = 0; t < 4; t++) begin
            run_xfer(0, 10, pen);
            check("rr_done0", done0, (t % 2) == 0);
            check("rr_done1", done1, (t % 2) == 1);
        end
        req0 = 1'b0; req1 = 1'b0;
        check("rr_rdata0", rdata0, 32'hCAFE0000);
        check("rr_rdata1", rdata1, 32'hCAFE0000);
        tick();
        check("rr_idle", busy, 1'b0);

        // PREADY never rises: timeout after 16 wait cycles
        PRDATA = 32'h55AA55AA;
        req0 = 1'b1; wr0 = 1'b0; addr0 = 4'h3;
        run_xfer(1000, 40, pen);
        check("to_pen_cycles", pen, 16);
        check("to_done0", done0, 1'b1);
        check("to_err0", err0, 1'b1);
        check("to_rdata0", rdata0, 0);
        check("to_psel", PSEL, 1'b0);
        check("to_busy", busy, 1'b0);
        check("to_rdata1_held", rdata1, 32'hCAFE0000);
        req0 = 1'b0;
        tick();
        check("to_done_pulse", {done0, err0}, 2'b00);

        // PREADY on the timeout cycle completes normally
        PRDATA = 32'h0BADF00D;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 4'h5;
        run_xfer(15, 40, pen);
        check("pri_pen_cycles", pen, 16);
        check("pri_done1", done1, 1'b1);
        check("pri_err1", err1, 1'b0);
        check("pri_rdata1", rdata1, 32'h0BADF00D);
        req1 = 1'b0;
        tick();

        // a requester held high is ignored during its own done cycle
        req0 = 1'b1; wr0 = 1'b1; addr0 = 4'h7; wdata0 = 32'h77;
        run_xfer(0, 10, pen);
        check("elig_done0", done0, 1'b1);
        tick();
        check("elig_gap_busy", busy, 1'b0);
        tick();
        check("elig_regrant_psel", PSEL, 1'b1);
        check("elig_regrant_addr", PADDR, 4'h7);
        run_xfer(0, 10, pen);
        check("elig_done0_2", done0, 1'b1);
        req0 = 1'b0;
        tick();

        // reset during ACCESS abandons the transfer
        req0 = 1'b1; wr0 = 1'b1; addr0 = 4'hC; wdata0 = 32'h11112222;
        tick();
        tick();
        check("rst_mid_pen", PENABLE, 1'b1);
        #2 PRESETn = 1'b0;
        #1;
        check("rst_mid_psel", PSEL, 1'b0);
        check("rst_mid_pen0", PENABLE, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        req0 = 1'b0;
        tick();
        check("rst_mid_done", done0, 1'b0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        tick();
        check("rst_rel_done", done0, 1'b0);
        check("rst_rel_busy", busy, 1'b0);
        req0 = 1'b1; wr0 = 1'b1; addr0 = 4'h6; wdata0 = 32'h600D;
        run_xfer(0, 10, pen);
        check("rst_post_pen", pen, 1);
        check("rst_post_done0", done0, 1'b1);
        check("rst_post_err0", err0, 1'b0);
        req0 = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_master_arb.md
APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 Parameter ADDR_W, 4, APB address width.
REQ-002 Parameter DATA_W, 32, APB data width.
REQ-003 Parameter TIMEOUT, 16, max ACCESS wait cycles with PREADY low; range 1..255; 0 disables timeout.
REQ-004 PCLK  in  1  sole clock; all state updates on rising edge.
REQ-005 PRESETn  in  1  reset, asynchronous, active-low.
REQ-006 req0 / req1  in  1  requester 0/1 transfer request, level.
REQ-007 wr0 / wr1  in  1  requester direction: 1 = write, 0 = read.
REQ-008 addr0 / addr1  in  ADDR_W  requester address.
REQ-009 wdata0 / wdata1  in  DATA_W  requester write data.
REQ-010 done0 / done1  out  1  one-cycle completion pulse to requester.
REQ-011 err0 / err1  out  1  valid with done; 1 = transfer ended by timeout.
REQ-012 rdata0 / rdata1  out  DATA_W  read data; valid with done.
REQ-013 PSEL, PENABLE, PWRITE  out  1 each  APB master controls.
REQ-014 PADDR  out  ADDR_W; PWDATA  out  DATA_W  APB master address/write data.
REQ-015 PRDATA  in  DATA_W  APB read data.
REQ-016 PREADY  in  1  slave ready; tie high for zero-wait slaves.
REQ-017 busy  out  1  high whenever state is not IDLE.

Function
REQ-018 FSM states IDLE, SETUP, ACCESS; all APB outputs driven from registers, no combinational path from inputs to outputs.
REQ-019 IDLE: PSEL=0, PENABLE=0; if any eligible req, latch winner's wr/addr/wdata into PWRITE/PADDR/PWDATA, record grant owner, next state SETUP.
REQ-020 SETUP: PSEL=1, PENABLE=0, exactly one cycle, next state ACCESS; PADDR/PWRITE/PWDATA held.
REQ-021 ACCESS: PSEL=1, PENABLE=1; on edge with PREADY=1 -> capture PRDATA (read) or 0 (write) into owner's rdata, pulse owner's done with err=0, next state IDLE.
REQ-022 ACCESS wait: wait counter increments each ACCESS cycle with PREADY=0; when count reaches TIMEOUT and PREADY still 0 -> owner's done=1, err=1, rdata=0, next state IDLE.
REQ-023 Wait counter clears on entry to SETUP; PREADY=1 on the timeout cycle takes priority (normal completion, err=0).
REQ-024 done/err asserted for exactly the cycle after the completing edge (coincides with the IDLE cycle); rdata holds its value until that requester's next done.
REQ-025 Eligibility: a requester whose done is high in the current cycle is ignored in that cycle; new requests from it are taken from the following cycle.
REQ-026 Arbitration round-robin: pointer last records the last-granted requester; single eligible req wins; if both eligible, the one != last wins.
REQ-027 Minimum transfer length 3 cycles (IDLE, SETUP, ACCESS); with both reqs held continuously, grants alternate 0,1,0,1.
REQ-028 Requester shall hold req/wr/addr/wdata stable from assertion until done; arbiter samples them only in IDLE at grant.
REQ-029 req deasserted after grant does not abort the transfer; the transfer completes and done still pulses.
REQ-030 PSEL never high in IDLE; PENABLE never high without PSEL; PENABLE never high in the first PSEL cycle.
REQ-031 busy=1 in SETUP and ACCESS, 0 in IDLE.

Reset
REQ-032 PRESETn low immediately forces state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, done0/1=0, err0/1=0, rdata0/1=0, busy=0, wait counter=0, last=1 (requester 0 wins first tie).
REQ-033 Reset asserted mid-transfer abandons the transfer with no done pulse; after release, operation resumes from IDLE on the first rising edge.

Verification
REQ-034 req0 write addr=0x4 wdata=0xDEADBEEF, PREADY=1 -> SETUP next cycle with PADDR=0x4, PWRITE=1; ACCESS next; done0=1, err0=0 on 4th cycle after req.
REQ-035 req1 read addr=0x8, PRDATA=0x12345678, PREADY low 3 cycles -> PENABLE high 4 cycles; done1=1 with rdata1=0x12345678, err1=0.
REQ-036 req0 and req1 asserted same cycle after reset, held for 4 transfers -> grant order 0,1,0,1; no two consecutive grants to same requester.
REQ-037 TIMEOUT=16, PREADY held 0 -> after 16 wait cycles done0=1, err0=1, rdata0=0; FSM returns to IDLE, PSEL=0.
REQ-038 PRESETn asserted in ACCESS -> PSEL/PENABLE=0 asynchronously, no done pulse; after release a new req0 completes normally.
REQ-039 Protocol checker throughout all scenarios: REQ-030 holds; PADDR/PWRITE/PWDATA stable from SETUP to completion.
